wb_cfg_master: RTL
==================

WB_CFG_MASTER -- requirements
Module: wb_cfg_master

Interface
REQ-001 SHALL have parameter ADDR_BW, default 32, Wishbone address width.
REQ-002 SHALL have parameter DATA_BW, default 32, Wishbone data width; SEL width = DATA_BW/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum bus cycles awaiting ack (1..65535).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL provide ports, clock and reset first:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_adr_i  in  ADDR_BW  target address
- cmd_dat_i  in  DATA_BW  write data
- cmd_sel_i  in  DATA_BW/8  byte selects
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_dat_o  out  DATA_BW  read data (0 for writes/errors)
- rsp_err_o  out  1  transaction timed out
- wbm_cyc_o / wbm_stb_o / wbm_we_o  out  1  Wishbone classic master controls
- wbm_adr_o  out  ADDR_BW;  wbm_dat_o  out  DATA_BW;  wbm_sel_o  out  DATA_BW/8
- wbm_ack_i  in  1;  wbm_dat_i  in  DATA_BW  slave ack / read data

Function
REQ-006 SHALL implement FSM states IDLE, BUS, RESP; one transaction outstanding at a time.
REQ-007 cmd_ready_o SHALL be 1 only in IDLE (combinational from state, not from cmd_valid_i).
REQ-008 On IDLE & cmd_valid_i: register we/adr/dat/sel onto wbm_*_o, assert wbm_cyc_o and wbm_stb_o from next cycle, go BUS.
REQ-009 In BUS, wbm_cyc_o=wbm_stb_o=1 and all wbm_*_o outputs SHALL stay stable until termination.
REQ-010 On a rising edge with BUS & wbm_ack_i: deassert cyc/stb next cycle, capture rsp_dat_o = wbm_dat_i for reads (0 for writes), rsp_err_o=0, go RESP.
REQ-011 Minimum command-accept to rsp_valid_o latency SHALL be 2 cycles (ack in first BUS cycle).
REQ-012 wbm_ack_i outside BUS SHALL be ignored.
REQ-013 In RESP: rsp_valid_o=1, rsp_dat_o/rsp_err_o held stable until rsp_ready_i; on rsp_valid_o & rsp_ready_i go IDLE next cycle.
REQ-014 No new command accepted while in BUS or RESP (back-to-back throughput: one transaction per 3 cycles minimum).
REQ-015 wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o SHALL be 0 whenever wbm_cyc_o=0.

Reset
REQ-016 With rst_i=1 at a clock edge: state=IDLE, all wbm_*_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, timeout counter=0.
REQ-017 Reset during BUS or RESP SHALL abort the transaction: cyc/stb low next cycle, no response produced, pending response discarded.

Configuration
REQ-018 Macro WB_CFG_MASTER_TIMEOUT_EN SHALL compile in the timeout counter.
REQ-019 With macro: counter clears on BUS entry, increments each BUS cycle without ack; when counter reaches TIMEOUT_CYCLES with no ack, deassert cyc/stb next cycle, rsp_err_o=1, rsp_dat_o=0, go RESP.
REQ-020 With macro, ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: normal response, rsp_err_o=0.
REQ-021 Without macro: no counter logic, BUS waits indefinitely for ack, rsp_err_o tied 0.

Verification
REQ-022 Write adr 0x30000000, dat 0xDEADBEEF, sel 0xF, ack on 3rd BUS cycle -> cyc/stb high exactly 3 cycles with stable adr/dat/we=1, rsp_valid_o=1, rsp_dat_o=0, rsp_err_o=0.
REQ-023 Read adr 0x30000010, ack in 1st BUS cycle with wbm_dat_i=0x12345678 -> rsp_valid_o 2 cycles after accept, rsp_dat_o=0x12345678.
REQ-024 rsp_ready_i low 5 cycles after read -> rsp_valid_o and rsp_dat_o held 5+ cycles, cmd_ready_o=0 throughout, new cmd_valid_i not accepted.
REQ-025 TIMEOUT_CYCLES=16, macro defined, no ack -> cyc/stb drop after 16 BUS cycles, rsp_err_o=1, rsp_dat_o=0; ack on cycle 16 -> rsp_err_o=0.
REQ-026 rst_i pulsed on 2nd BUS cycle -> cyc/stb=0 next cycle, rsp_valid_o never asserts, cmd_ready_o=1 after reset release.
REQ-027 Stray wbm_ack_i=1 during IDLE and RESP -> no state change, no extra response.

Source files
------------

// File: rtl/wb_cfg_master.sv
// Single-outstanding Wishbone classic master driven by a valid/ready command port.
// Optional `WB_CFG_MASTER_TIMEOUT_EN adds a bus-cycle timeout reporting rsp_err_o.
module wb_cfg_master #(
  parameter int unsigned ADDR_BW        = 32,
  parameter int unsigned DATA_BW        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDR_BW-1:0]   cmd_adr_i,
  input  logic [DATA_BW-1:0]   cmd_dat_i,
  input  logic [DATA_BW/8-1:0] cmd_sel_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATA_BW-1:0]   rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [ADDR_BW-1:0]   wbm_adr_o,
  output logic [DATA_BW-1:0]   wbm_dat_o,
  output logic [DATA_BW/8-1:0] wbm_sel_o,
  input  logic                 wbm_ack_i,
  input  logic [DATA_BW-1:0]   wbm_dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state, state_nxt;
  logic   ack_take;
  logic   timeout_hit;

  assign ack_take = (state == BUS) && wbm_ack_i;

`ifdef WB_CFG_MASTER_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        rsp_err_q;

  // Count value k means k+1 BUS cycles have elapsed; an ack in the last cycle still wins.
  assign timeout_hit = (state == BUS) && !wbm_ack_i && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign rsp_err_o   = rsp_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid_i) to_cnt <= '0;
        BUS: begin
          if (ack_take || timeout_hit) begin
            rsp_err_q <= !ack_take;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        RESP: if (rsp_ready_i) rsp_err_q <= 1'b0;
        default: ;
      endcase
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err_o   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid_i) state_nxt = BUS;
      BUS:     if (ack_take || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  assign cmd_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign wbm_cyc_o   = (state == BUS);
  assign wbm_stb_o   = (state == BUS);

  // Bus-side registers are loaded on accept and cleared on termination so they read 0 outside a cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      rsp_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wbm_we_o  <= cmd_we_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            wbm_sel_o <= cmd_sel_i;
          end
        end
        BUS: begin
          if (ack_take || timeout_hit) begin
            rsp_dat_o <= (ack_take && !wbm_we_o) ? wbm_dat_i : '0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
          end
        end
        RESP: if (rsp_ready_i) rsp_dat_o <= '0;
        default: ;
      endcase
    end
  end

endmodule
